// File: rtl/mult_fix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_fix_pkg
//  Description : Shared constants for the pipelined signed fixed-point
//                multiplier: rounding/saturation mode encodings and the
//                default word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_fix_pkg;

    // Default word geometry: total width and fractional bits
    localparam int DEFAULT_N = 32;
    localparam int DEFAULT_Q = 12;

    // rnd_mode encodings
    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    // sat_mode encodings
    localparam logic SAT_WRAP    = 1'b0;
    localparam logic SAT_CLAMP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fix_quantize_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fix_quantize_sat
//  Description : Reduces a full-width 2N-bit signed product to an N-bit
//                Q-format word. Optional round-half-up, range check against
//                N signed bits, and optional clamp to the signed extremes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fix_quantize_sat
    import mult_fix_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int Q = DEFAULT_Q
) (
    input  logic [2*N-1:0] i_prod,
    input  logic           i_rnd_mode,
    input  logic           i_sat_mode,
    output logic [N-1:0]   o_data,
    output logic           o_ovf
);

    // Half of one output LSB, in product units; added before the shift to round
    localparam logic [2*N:0] c_HALF_LSB = {{(2*N){1'b0}}, 1'b1} << (Q - 1);

    logic signed [2*N:0] w_ext;
    logic signed [2*N:0] w_sum;
    logic signed [2*N:0] w_shr;
    logic                w_fits;

    // Round (one guard bit of headroom), floor-shift, range check and clamp
    always_comb begin
        w_ext  = {i_prod[2*N-1], i_prod};
        w_sum  = w_ext + ((i_rnd_mode == RND_HALF_UP) ? c_HALF_LSB : '0);
        w_shr  = w_sum >>> Q;
        // Fits in N signed bits when every bit above the N-bit sign matches it
        w_fits = (w_shr[2*N:N-1] == {(N+2){w_shr[N-1]}});
        o_ovf  = !w_fits;
        if (!w_fits && (i_sat_mode == SAT_CLAMP)) begin
            o_data = w_shr[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            o_data = w_shr[N-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_fix_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_fix_pipe
//  Description : Three-stage signed fixed-point multiplier with valid/ready
//                handshakes. S1 registers operands and modes, S2 holds the
//                exact 2N-bit product, S3 holds the quantized result. The
//                whole pipe advances together whenever the output slot is
//                empty or being consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_fix_pipe
    import mult_fix_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int Q = DEFAULT_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         rnd_mode,
    input  logic         sat_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);

    logic                w_advance;

    logic                r_s1_valid;
    logic [N-1:0]        r_s1_a;
    logic [N-1:0]        r_s1_b;
    logic                r_s1_rnd;
    logic                r_s1_sat;

    logic                r_s2_valid;
    logic [2*N-1:0]      r_s2_prod;
    logic                r_s2_rnd;
    logic                r_s2_sat;

    logic                r_s3_valid;
    logic [N-1:0]        r_s3_data;
    logic                r_s3_ovf;

    logic signed [2*N-1:0] w_prod;
    logic [N-1:0]        w_q_data;
    logic                w_q_ovf;

    // Whole pipe moves when the output slot is free or is being taken
    assign w_advance = !r_s3_valid || out_ready;
    assign in_ready  = w_advance && !rst;

    // Operands sign-extended to full width first so the product is exact,
    // including most-negative squared
    assign w_prod = $signed({{N{r_s1_a[N-1]}}, r_s1_a})
                  * $signed({{N{r_s1_b[N-1]}}, r_s1_b});

    // Stage valid bits: cleared by reset, shifted (bubbles included) on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    // S1/S2 datapath registers; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_a    <= in_a;
            r_s1_b    <= in_b;
            r_s1_rnd  <= rnd_mode;
            r_s1_sat  <= sat_mode;
            r_s2_prod <= w_prod;
            r_s2_rnd  <= r_s1_rnd;
            r_s2_sat  <= r_s1_sat;
        end
    end

    fix_quantize_sat #(
        .N (N),
        .Q (Q)
    ) u_quant (
        .i_prod     (r_s2_prod),
        .i_rnd_mode (r_s2_rnd),
        .i_sat_mode (r_s2_sat),
        .o_data     (w_q_data),
        .o_ovf      (w_q_ovf)
    );

    // Output stage: reset to zero, loads only real results, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_ovf   <= 1'b0;
        end else if (w_advance) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_data <= w_q_data;
                r_s3_ovf  <= w_q_ovf;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_data  = r_s3_data;
    assign out_ovf   = r_s3_ovf;

endmodule
`default_nettype wire
